// File: rtl/keypad_digit_encoder.sv
// keypad_digit_encoder: scans a 4x4 active-low matrix keypad, debounces it and emits one hex digit per new keypress.
// Latency: 2-cycle pin synchroniser; load rises the cycle after the DEBOUNCE_SAMPLES-th matching sample strobe.
// Backpressure: none; load is a one-cycle strobe, digit holds until the next accepted key.
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset
//   cols     keypad columns, pulled up, low = key closed on the driven row (asynchronous to clk)
//   rows     keypad row drive, active-low, exactly one row low at any time
//   digit    hex code of the last accepted key
//   load     one-cycle pulse when digit updates
//   instrEn  high while the accepted key is held, until its release is debounced
module keypad_digit_encoder #(
    parameter int SCAN_DIV         = 4096,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [3:0] digit,
    output logic       load,
    output logic       instrEn
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SAMPLES);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    // Row/column position to hex code, laid out as printed on the keypad.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = 4'h0;
        case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            4'hF: k = 4'hD;
            default: k = 4'h0;
        endcase
        return k;
    endfunction

    // Registered state
    logic [3:0]       cols_meta;
    logic [3:0]       cols_sync;
    logic [DIV_W-1:0] div_cnt;
    state_t           state;
    logic [1:0]       row_idx;
    logic [1:0]       cand_col;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] rel_cnt;

    // Next-state values
    state_t           state_nxt;
    logic [1:0]       row_nxt;
    logic [1:0]       cand_nxt;
    logic [CNT_W-1:0] match_nxt;
    logic [CNT_W-1:0] rel_nxt;
    logic [3:0]       digit_nxt;
    logic             load_nxt;
    logic             instr_nxt;

    logic             strobe;
    logic             is_none;
    logic             is_single;
    logic [1:0]       single_col;
    logic [CNT_W-1:0] match_inc;
    logic [CNT_W-1:0] rel_inc;
    logic             take;

    assign strobe    = (div_cnt == DIV_LAST);
    assign rows      = ~(4'b0001 << row_idx);
    // match_cnt is kept at zero while scanning, so the same increment
    // serves the first sample in SCAN and the follow-ups in DEBOUNCE.
    assign match_inc = match_cnt + CNT_W'(1);
    assign rel_inc   = rel_cnt + CNT_W'(1);

    // Classify the synchronised column sample: none, exactly one, or several low.
    always_comb begin
        is_none    = (cols_sync == 4'b1111);
        is_single  = 1'b0;
        single_col = 2'd0;
        case (cols_sync)
            4'b1110: begin is_single = 1'b1; single_col = 2'd0; end
            4'b1101: begin is_single = 1'b1; single_col = 2'd1; end
            4'b1011: begin is_single = 1'b1; single_col = 2'd2; end
            4'b0111: begin is_single = 1'b1; single_col = 2'd3; end
            default: begin is_single = 1'b0; single_col = 2'd0; end
        endcase
    end

    always_comb begin
        state_nxt = state;
        row_nxt   = row_idx;
        cand_nxt  = cand_col;
        match_nxt = match_cnt;
        rel_nxt   = rel_cnt;
        digit_nxt = digit;
        load_nxt  = 1'b0;
        instr_nxt = instrEn;
        take      = 1'b0;

        if (strobe) begin
            case (state)
                SCAN: begin
                    if (is_single) begin
                        cand_nxt = single_col;
                        if (match_inc == CNT_DONE) begin
                            take = 1'b1;
                        end else begin
                            match_nxt = match_inc;
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        row_nxt = row_idx + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (is_single && (single_col == cand_col)) begin
                        if (match_inc == CNT_DONE) begin
                            take = 1'b1;
                        end else begin
                            match_nxt = match_inc;
                        end
                    end else begin
                        // Bounce or chord during debounce: abandon and keep scanning.
                        state_nxt = SCAN;
                        match_nxt = '0;
                        row_nxt   = row_idx + 2'd1;
                    end
                end
                HELD: begin
                    // Only a clean all-high run counts towards release, so any
                    // extra key pressed while held just holds off the release.
                    if (is_none) begin
                        if (rel_inc == CNT_DONE) begin
                            state_nxt = SCAN;
                            rel_nxt   = '0;
                            instr_nxt = 1'b0;
                        end else begin
                            rel_nxt = rel_inc;
                        end
                    end else begin
                        rel_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = SCAN;
                end
            endcase
        end

        if (take) begin
            // Rows are frozen since the first sample, so row_idx is the candidate row.
            digit_nxt = key_map(row_idx, single_col);
            load_nxt  = 1'b1;
            instr_nxt = 1'b1;
            state_nxt = HELD;
            match_nxt = '0;
            rel_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cols_meta <= 4'b1111;
            cols_sync <= 4'b1111;
            div_cnt   <= '0;
            state     <= SCAN;
            row_idx   <= 2'd0;
            cand_col  <= 2'd0;
            match_cnt <= '0;
            rel_cnt   <= '0;
            digit     <= 4'h0;
            load      <= 1'b0;
            instrEn   <= 1'b0;
        end else begin
            cols_meta <= cols;
            cols_sync <= cols_meta;
            div_cnt   <= strobe ? '0 : div_cnt + DIV_W'(1);
            state     <= state_nxt;
            row_idx   <= row_nxt;
            cand_col  <= cand_nxt;
            match_cnt <= match_nxt;
            rel_cnt   <= rel_nxt;
            digit     <= digit_nxt;
            load      <= load_nxt;
            instrEn   <= instr_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_digit_encoder.sv
// tb_keypad_digit_encoder: directed keypad scenarios with a digit scoreboard popped on every load pulse.
// Latency: sample strobes every 4 cycles, 3 matching samples to accept or release a key.
// Backpressure: none; the keypad model reacts combinationally to the driven row.
module tb_keypad_digit_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cols;
    logic [3:0]  rows;
    logic [3:0]  digit;
    logic        load;
    logic        instrEn;

    logic [15:0] pressed;        // bit r*4+c = key at row r, column c closed
    logic [1:0]  tb_div;         // sample-period phase reference, restarts on reset
    logic [3:0]  exp_q[$];
    logic [3:0]  model_digit;
    logic [3:0]  rot_tab[4];
    logic        prev_load = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          load_count = 0;

    keypad_digit_encoder #(
        .SCAN_DIV        (4),
        .DEBOUNCE_SAMPLES(3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cols   (cols),
        .rows   (rows),
        .digit  (digit),
        .load   (load),
        .instrEn(instrEn)
    );

    always #5 clk = ~clk;

    // Passive keypad: a closed key pulls its column low only while its row is driven.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!rows[r]) cols = cols & ~pressed[r*4 +: 4];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tb_div <= 2'd0;
        else        tb_div <= tb_div + 2'd1;
    end

    // Scoreboard monitor: every load pulse consumes one expected digit.
    always @(negedge clk) begin
        logic [3:0] e;
        if (reset) begin
            if (load) begin
                load_count++;
                checks++;
                if (prev_load) begin
                    errors++;
                    $display("FAIL load_single_cycle: load high %0d, previous cycle load %0d, required 0", load, prev_load);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_load: load with digit %h, no key press expected", digit);
                end else begin
                    e = exp_q.pop_front();
                    if (digit !== e) begin
                        errors++;
                        $display("FAIL load_digit: got %h, expected %h", digit, e);
                    end
                    model_digit = e;
                end
            end
            prev_load = load;
        end else begin
            prev_load = 1'b0;
        end
    end

    // Advance to just after the next sample strobe edge.
    task automatic step();
        do @(negedge clk); while (tb_div != 2'd3);
        @(negedge clk);
        #1;
    endtask

    task automatic check_step(input string name, input logic [3:0] rows_e,
                              input logic instr_e, input logic load_e);
        step();
        checks++;
        if (rows !== rows_e) begin
            errors++;
            $display("FAIL %s rows: got %b, expected %b", name, rows, rows_e);
        end
        checks++;
        if (instrEn !== instr_e) begin
            errors++;
            $display("FAIL %s instrEn: got %b, expected %b", name, instrEn, instr_e);
        end
        checks++;
        if (load !== load_e) begin
            errors++;
            $display("FAIL %s load: got %b, expected %b", name, load, load_e);
        end
        checks++;
        if (digit !== model_digit) begin
            errors++;
            $display("FAIL %s digit_hold: got %h, expected %h", name, digit, model_digit);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (rows !== 4'b1110) begin
            errors++;
            $display("FAIL %s rows: got %b, expected 1110", name, rows);
        end
        checks++;
        if (digit !== 4'h0) begin
            errors++;
            $display("FAIL %s digit: got %h, expected 0", name, digit);
        end
        checks++;
        if (load !== 1'b0) begin
            errors++;
            $display("FAIL %s load: got %b, expected 0", name, load);
        end
        checks++;
        if (instrEn !== 1'b0) begin
            errors++;
            $display("FAIL %s instrEn: got %b, expected 0", name, instrEn);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rot_tab[0] = 4'b1110;
        rot_tab[1] = 4'b1101;
        rot_tab[2] = 4'b1011;
        rot_tab[3] = 4'b0111;
        reset       = 1'b0;
        pressed     = 16'h0000;
        model_digit = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        reset = 1'b1;
        #1;

        // Idle scan: rows rotate once per sample period, nothing reported.
        for (int k = 1; k <= 25; k++) check_step("idle", rot_tab[k % 4], 1'b0, 1'b0);

        // r2c1 -> 8; row 1 is driven now, row 2 comes next.
        pressed[9] = 1'b1;
        exp_q.push_back(4'h8);
        check_step("r2c1_scan", 4'b1011, 1'b0, 1'b0);
        check_step("r2c1_deb1", 4'b1011, 1'b0, 1'b0);
        check_step("r2c1_deb2", 4'b1011, 1'b0, 1'b0);
        check_step("r2c1_load", 4'b1011, 1'b1, 1'b1);
        check_step("r2c1_held", 4'b1011, 1'b1, 1'b0);
        check_step("r2c1_held", 4'b1011, 1'b1, 1'b0);
        pressed[9] = 1'b0;
        check_step("r2c1_rel1", 4'b1011, 1'b1, 1'b0);
        check_step("r2c1_rel2", 4'b1011, 1'b1, 1'b0);
        check_step("r2c1_rel3", 4'b1011, 1'b0, 1'b0);
        check_step("r2c1_resume", 4'b0111, 1'b0, 1'b0);

        // r3c1 bounces: one low sample, one high sample, abandoned.
        pressed[13] = 1'b1;
        check_step("bounce_low", 4'b0111, 1'b0, 1'b0);
        pressed[13] = 1'b0;
        check_step("bounce_high", 4'b1110, 1'b0, 1'b0);
        // Then stable low -> 0 once row 3 comes round again.
        pressed[13] = 1'b1;
        exp_q.push_back(4'h0);
        check_step("r3c1_scan", 4'b1101, 1'b0, 1'b0);
        check_step("r3c1_scan", 4'b1011, 1'b0, 1'b0);
        check_step("r3c1_scan", 4'b0111, 1'b0, 1'b0);
        check_step("r3c1_deb1", 4'b0111, 1'b0, 1'b0);
        check_step("r3c1_deb2", 4'b0111, 1'b0, 1'b0);
        check_step("r3c1_load", 4'b0111, 1'b1, 1'b1);
        check_step("r3c1_held", 4'b0111, 1'b1, 1'b0);
        pressed[13] = 1'b0;
        check_step("r3c1_rel1", 4'b0111, 1'b1, 1'b0);
        check_step("r3c1_rel2", 4'b0111, 1'b1, 1'b0);
        check_step("r3c1_rel3", 4'b0111, 1'b0, 1'b0);
        check_step("r3c1_resume", 4'b1110, 1'b0, 1'b0);

        // r0c3 -> A, then r0c0 added mid-hold and released last.
        pressed[3] = 1'b1;
        exp_q.push_back(4'hA);
        check_step("r0c3_deb1", 4'b1110, 1'b0, 1'b0);
        check_step("r0c3_deb2", 4'b1110, 1'b0, 1'b0);
        check_step("r0c3_load", 4'b1110, 1'b1, 1'b1);
        check_step("r0c3_held", 4'b1110, 1'b1, 1'b0);
        pressed[0] = 1'b1;
        check_step("chord_held", 4'b1110, 1'b1, 1'b0);
        check_step("chord_held", 4'b1110, 1'b1, 1'b0);
        pressed[3] = 1'b0;
        check_step("rollover_held", 4'b1110, 1'b1, 1'b0);
        check_step("rollover_held", 4'b1110, 1'b1, 1'b0);
        pressed[0] = 1'b0;
        check_step("chord_rel1", 4'b1110, 1'b1, 1'b0);
        check_step("chord_rel2", 4'b1110, 1'b1, 1'b0);
        check_step("chord_rel3", 4'b1110, 1'b0, 1'b0);
        check_step("chord_resume", 4'b1101, 1'b0, 1'b0);

        // r1c0 + r1c2 together from the start: MULTI, keeps rotating.
        pressed[4] = 1'b1;
        pressed[6] = 1'b1;
        check_step("multi", 4'b1011, 1'b0, 1'b0);
        check_step("multi", 4'b0111, 1'b0, 1'b0);
        check_step("multi", 4'b1110, 1'b0, 1'b0);
        check_step("multi", 4'b1101, 1'b0, 1'b0);
        check_step("multi", 4'b1011, 1'b0, 1'b0);
        pressed[4] = 1'b0;
        pressed[6] = 1'b0;

        // r2c3 -> C, interrupted by reset during debounce.
        pressed[11] = 1'b1;
        check_step("r2c3_deb1", 4'b1011, 1'b0, 1'b0);
        reset = 1'b0;
        model_digit = 4'h0;
        #1;
        check_reset("mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        exp_q.push_back(4'hC);
        check_step("r2c3_scan", 4'b1101, 1'b0, 1'b0);
        check_step("r2c3_scan", 4'b1011, 1'b0, 1'b0);
        check_step("r2c3_deb1", 4'b1011, 1'b0, 1'b0);
        check_step("r2c3_deb2", 4'b1011, 1'b0, 1'b0);
        check_step("r2c3_load", 4'b1011, 1'b1, 1'b1);
        pressed[11] = 1'b0;
        check_step("r2c3_rel1", 4'b1011, 1'b1, 1'b0);
        check_step("r2c3_rel2", 4'b1011, 1'b1, 1'b0);
        check_step("r2c3_rel3", 4'b1011, 1'b0, 1'b0);

        // Same key again after a debounced release: new pulse, same digit.
        pressed[11] = 1'b1;
        exp_q.push_back(4'hC);
        check_step("repeat_deb1", 4'b1011, 1'b0, 1'b0);
        check_step("repeat_deb2", 4'b1011, 1'b0, 1'b0);
        check_step("repeat_load", 4'b1011, 1'b1, 1'b1);
        pressed[11] = 1'b0;
        check_step("repeat_rel1", 4'b1011, 1'b1, 1'b0);
        check_step("repeat_rel2", 4'b1011, 1'b1, 1'b0);
        check_step("repeat_rel3", 4'b1011, 1'b0, 1'b0);
        check_step("repeat_resume", 4'b0111, 1'b0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_load: %0d expected digits never loaded, required 0", exp_q.size());
        end
        checks++;
        if (load_count != 5) begin
            errors++;
            $display("FAIL load_count: got %0d load pulses, expected 5", load_count);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
